// File: rtl/switch_allocator.sv
`default_nettype none
// ============================================================================
// Module   : switch_allocator
// Purpose  : Per-output-port packet allocator for the chiplet switch.
//            Each output port arbitrates round-robin among input buffers
//            that request it. The winner holds the port for a whole packet.
//            Downstream credits are tracked per (output port, VC).
// Ports    : clk, rst           - clock, synchronous active-high reset
//            req_valid/outport/vc - per-buffer routed packet-head requests
//            flit_sent/packet_sent - per-output flit / tail-flit departures
//            credit_granted     - per (port, VC) credit returns, index p*NUM_VCS+v
//            buffer_grant       - buffer owns an output port
//            outport_busy/sel/vc - per-port lock state, owner and VC
//            credit_avail       - locked VC has credit (flit may be sent)
//            credit_err         - sticky protocol-violation flag
//            pkt_count          - per-port 16-bit packet counters
//                                 (only with SWITCH_ALLOC_STATS_EN)
// Options  : `define SWITCH_ALLOC_STATS_EN adds pkt_count.
// Revision : 1.0 - initial release
// ============================================================================
module switch_allocator #(
  parameter int NUM_OUTPORTS = 4,
  parameter int NUM_BUFFERS  = 4,
  parameter int NUM_VCS      = 2,
  parameter int BUFFER_DEPTH = 8,
  localparam int OW = $clog2(NUM_OUTPORTS),
  localparam int BW = $clog2(NUM_BUFFERS),
  localparam int VW = $clog2(NUM_VCS),
  localparam int CW = $clog2(BUFFER_DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_BUFFERS-1:0]      req_valid,
  input  logic [NUM_BUFFERS*OW-1:0]   req_outport,
  input  logic [NUM_BUFFERS*VW-1:0]   req_vc,
  input  logic [NUM_OUTPORTS-1:0]     flit_sent,
  input  logic [NUM_OUTPORTS-1:0]     packet_sent,
  input  logic [NUM_OUTPORTS*NUM_VCS-1:0] credit_granted,
  output logic [NUM_BUFFERS-1:0]      buffer_grant,
  output logic [NUM_OUTPORTS-1:0]     outport_busy,
  output logic [NUM_OUTPORTS*BW-1:0]  outport_sel,
  output logic [NUM_OUTPORTS*VW-1:0]  outport_vc,
  output logic [NUM_OUTPORTS-1:0]     credit_avail,
  output logic                        credit_err
`ifdef SWITCH_ALLOC_STATS_EN
  ,
  output logic [NUM_OUTPORTS*16-1:0]  pkt_count
`endif
);

  typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

  localparam logic [CW-1:0] C_DEPTH = CW'(BUFFER_DEPTH);

  state_t          r_state  [NUM_OUTPORTS];
  logic [BW-1:0]   r_sel    [NUM_OUTPORTS];
  logic [VW-1:0]   r_vc     [NUM_OUTPORTS];
  logic [BW-1:0]   r_rr     [NUM_OUTPORTS];
  logic [CW-1:0]   r_credit [NUM_OUTPORTS][NUM_VCS];
  logic [NUM_BUFFERS-1:0] r_grant;
  logic            r_err;

  logic [NUM_BUFFERS-1:0] w_elig   [NUM_OUTPORTS];
  logic                   w_found  [NUM_OUTPORTS];
  logic [BW-1:0]          w_win    [NUM_OUTPORTS];
  logic [VW-1:0]          w_win_vc [NUM_OUTPORTS];
  logic [CW-1:0]          w_credit_next [NUM_OUTPORTS][NUM_VCS];
  logic [NUM_BUFFERS-1:0] w_grant_set;
  logic [NUM_BUFFERS-1:0] w_grant_clr;
  logic                   w_err;
  logic [BW-1:0]          w_idx;
  logic                   w_inc;
  logic                   w_dec;

  // Eligibility and round-robin pick per output port.
  always_comb begin
    w_idx = '0;
    for (int p = 0; p < NUM_OUTPORTS; p++) begin
      w_elig[p]   = '0;
      w_found[p]  = 1'b0;
      w_win[p]    = '0;
      w_win_vc[p] = '0;
      for (int b = 0; b < NUM_BUFFERS; b++) begin
        if (req_valid[b] && (req_outport[b*OW +: OW] == OW'(p)) &&
            (r_credit[p][req_vc[b*VW +: VW]] != '0) && !r_grant[b])
          w_elig[p][b] = 1'b1;
      end
      for (int i = 0; i < NUM_BUFFERS; i++) begin
        w_idx = BW'((int'(r_rr[p]) + i) % NUM_BUFFERS);
        if (!w_found[p] && w_elig[p][w_idx]) begin
          w_found[p] = 1'b1;
          w_win[p]   = w_idx;
        end
      end
      w_win_vc[p] = req_vc[int'(w_win[p])*VW +: VW];
    end
  end

  // Grant set/clear vectors, credit next-state and error detection.
  // A buffer is granted by at most one port per cycle because it only
  // requests a single output port.
  always_comb begin
    w_grant_set = '0;
    w_grant_clr = '0;
    w_err       = 1'b0;
    w_inc       = 1'b0;
    w_dec       = 1'b0;
    for (int p = 0; p < NUM_OUTPORTS; p++) begin
      if (r_state[p] == S_IDLE) begin
        if (w_found[p])
          w_grant_set[w_win[p]] = 1'b1;
        if (flit_sent[p] || packet_sent[p])
          w_err = 1'b1;
      end else if (packet_sent[p]) begin
        w_grant_clr[r_sel[p]] = 1'b1;
      end
      for (int v = 0; v < NUM_VCS; v++) begin
        w_inc = credit_granted[p*NUM_VCS + v];
        w_dec = (r_state[p] == S_LOCKED) && (flit_sent[p] || packet_sent[p]) &&
                (r_vc[p] == VW'(v));
        w_credit_next[p][v] = r_credit[p][v];
        // Simultaneous return and consumption cancel out.
        if (w_inc && !w_dec) begin
          if (r_credit[p][v] == C_DEPTH) w_err = 1'b1;
          else w_credit_next[p][v] = r_credit[p][v] + 1'b1;
        end else if (w_dec && !w_inc) begin
          if (r_credit[p][v] == '0) w_err = 1'b1;
          else w_credit_next[p][v] = r_credit[p][v] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NUM_OUTPORTS; p++) begin
        r_state[p] <= S_IDLE;
        r_sel[p]   <= '0;
        r_vc[p]    <= '0;
        r_rr[p]    <= '0;
        for (int v = 0; v < NUM_VCS; v++)
          r_credit[p][v] <= C_DEPTH;
      end
      r_grant <= '0;
      r_err   <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_OUTPORTS; p++) begin
        case (r_state[p])
          S_IDLE: begin
            if (w_found[p]) begin
              r_state[p] <= S_LOCKED;
              r_sel[p]   <= w_win[p];
              r_vc[p]    <= w_win_vc[p];
            end
          end
          S_LOCKED: begin
            if (packet_sent[p]) begin
              r_state[p] <= S_IDLE;
              r_rr[p]    <= BW'((int'(r_sel[p]) + 1) % NUM_BUFFERS);
              r_sel[p]   <= '0;
              r_vc[p]    <= '0;
            end
          end
          default: r_state[p] <= S_IDLE;
        endcase
        for (int v = 0; v < NUM_VCS; v++)
          r_credit[p][v] <= w_credit_next[p][v];
      end
      r_grant <= (r_grant & ~w_grant_clr) | w_grant_set;
      if (w_err) r_err <= 1'b1;
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_OUTPORTS; p++) begin
      outport_busy[p]          = (r_state[p] == S_LOCKED);
      outport_sel[p*BW +: BW]  = r_sel[p];
      outport_vc[p*VW +: VW]   = r_vc[p];
      credit_avail[p]          = (r_state[p] == S_LOCKED) && (r_credit[p][r_vc[p]] != '0);
    end
  end

  assign buffer_grant = r_grant;
  assign credit_err   = r_err;

`ifdef SWITCH_ALLOC_STATS_EN
  generate
    for (genvar gp = 0; gp < NUM_OUTPORTS; gp++) begin : g_stats
      logic [15:0] r_pkt_cnt;
      always_ff @(posedge clk) begin
        if (rst)
          r_pkt_cnt <= '0;
        else if ((r_state[gp] == S_LOCKED) && packet_sent[gp])
          r_pkt_cnt <= r_pkt_cnt + 16'd1;
      end
      assign pkt_count[gp*16 +: 16] = r_pkt_cnt;
    end
  endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_switch_allocator.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_allocator
// Purpose  : Self-checking bench for switch_allocator: directed scenarios
//            followed by random traffic, compared cycle by cycle against a
//            behavioural model of the allocation and credit rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_switch_allocator;
  localparam int NO = 4;
  localparam int NB = 4;
  localparam int NV = 2;
  localparam int BD = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NB-1:0]   req_valid;
  logic [NB*2-1:0] req_outport;
  logic [NB-1:0]   req_vc;
  logic [NO-1:0]   flit_sent;
  logic [NO-1:0]   packet_sent;
  logic [NO*NV-1:0] credit_granted;
  logic [NB-1:0]   buffer_grant;
  logic [NO-1:0]   outport_busy;
  logic [NO*2-1:0] outport_sel;
  logic [NO-1:0]   outport_vc;
  logic [NO-1:0]   credit_avail;
  logic            credit_err;
`ifdef SWITCH_ALLOC_STATS_EN
  logic [NO*16-1:0] pkt_count;
`endif

  always #5 clk = ~clk;

  switch_allocator dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_outport(req_outport), .req_vc(req_vc),
    .flit_sent(flit_sent), .packet_sent(packet_sent),
    .credit_granted(credit_granted),
    .buffer_grant(buffer_grant), .outport_busy(outport_busy),
    .outport_sel(outport_sel), .outport_vc(outport_vc),
    .credit_avail(credit_avail), .credit_err(credit_err)
`ifdef SWITCH_ALLOC_STATS_EN
    , .pkt_count(pkt_count)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model state.
  int m_busy [NO];
  int m_sel  [NO];
  int m_vc   [NO];
  int m_rr   [NO];
  int m_cred [NO][NV];
  bit m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NO; p++) begin
      m_busy[p] = 0; m_sel[p] = 0; m_vc[p] = 0; m_rr[p] = 0;
      for (int v = 0; v < NV; v++) m_cred[p][v] = BD;
    end
    m_err = 0;
  endtask

  // Next state from the current model state and the inputs about to be sampled.
  task automatic model_step();
    int nbusy [NO];
    int nsel  [NO];
    int nvc   [NO];
    int nrr   [NO];
    int ncred [NO][NV];
    bit taken [NB];
    if (rst) begin
      model_reset();
      return;
    end
    for (int b = 0; b < NB; b++) taken[b] = 0;
    for (int p = 0; p < NO; p++) if (m_busy[p] != 0) taken[m_sel[p]] = 1;
    for (int p = 0; p < NO; p++) begin
      nbusy[p] = m_busy[p]; nsel[p] = m_sel[p]; nvc[p] = m_vc[p]; nrr[p] = m_rr[p];
      if (m_busy[p] == 0) begin
        for (int i = 0; i < NB; i++) begin
          int b = (m_rr[p] + i) % NB;
          if (nbusy[p] == 0 && req_valid[b] && int'(req_outport[b*2 +: 2]) == p &&
              m_cred[p][req_vc[b]] > 0 && !taken[b]) begin
            nbusy[p] = 1; nsel[p] = b; nvc[p] = int'(req_vc[b]);
          end
        end
        if (flit_sent[p] || packet_sent[p]) m_err = 1;
      end else if (packet_sent[p]) begin
        nbusy[p] = 0;
        nrr[p] = (m_sel[p] + 1) % NB;
      end
      for (int v = 0; v < NV; v++) begin
        bit inc = credit_granted[p*NV + v];
        bit dec = (m_busy[p] != 0) && (flit_sent[p] || packet_sent[p]) && (m_vc[p] == v);
        ncred[p][v] = m_cred[p][v];
        if (inc && !dec) begin
          if (m_cred[p][v] == BD) m_err = 1; else ncred[p][v] = m_cred[p][v] + 1;
        end else if (dec && !inc) begin
          if (m_cred[p][v] == 0) m_err = 1; else ncred[p][v] = m_cred[p][v] - 1;
        end
      end
    end
    for (int p = 0; p < NO; p++) begin
      m_busy[p] = nbusy[p]; m_sel[p] = nsel[p]; m_vc[p] = nvc[p]; m_rr[p] = nrr[p];
      for (int v = 0; v < NV; v++) m_cred[p][v] = ncred[p][v];
    end
  endtask

  // Owner and VC are only meaningful on locked ports, so both sides are masked.
  task automatic compare();
    logic [NB-1:0]   eg;
    logic [NO-1:0]   eb, ea;
    logic [NO*2-1:0] es, as_;
    logic [NO-1:0]   ev, av;
    eg = '0; eb = '0; ea = '0; es = '0; as_ = '0; ev = '0; av = '0;
    for (int p = 0; p < NO; p++) begin
      if (m_busy[p] != 0) begin
        eg[m_sel[p]] = 1'b1;
        eb[p] = 1'b1;
        ea[p] = (m_cred[p][m_vc[p]] != 0);
        es[p*2 +: 2] = 2'(m_sel[p]);
        as_[p*2 +: 2] = outport_sel[p*2 +: 2];
        ev[p] = 1'(m_vc[p]);
        av[p] = outport_vc[p];
      end
    end
    check("buffer_grant", 32'(buffer_grant), 32'(eg));
    check("outport_busy", 32'(outport_busy), 32'(eb));
    check("outport_sel", 32'(as_), 32'(es));
    check("outport_vc", 32'(av), 32'(ev));
    check("credit_avail", 32'(credit_avail), 32'(ea));
    check("credit_err", 32'(credit_err), 32'(m_err));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_outport = '0; req_vc = '0;
    flit_sent = '0; packet_sent = '0; credit_granted = '0;
  endtask

  int order [4] = '{0, 1, 3, 0};
  int n;

  initial begin
    model_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
    check("reset_sel", 32'(outport_sel), 32'd0);
    check("reset_vc", 32'(outport_vc), 32'd0);
    check("reset_busy", 32'(outport_busy), 32'd0);

    // Buffer 1 -> port 2, VC 0.
    req_valid = 4'b0010; req_outport[3:2] = 2'd2; req_vc[1] = 1'b0;
    tick();
    check("t1_busy2", 32'(outport_busy[2]), 32'd1);
    check("t1_sel2", 32'(outport_sel[5:4]), 32'd1);
    check("t1_grant", 32'(buffer_grant), 32'b0010);
    clear_inputs();
    packet_sent[2] = 1'b1;
    tick();
    clear_inputs();
    tick();

    // Buffers 0, 1, 3 contend for port 0.
    req_valid = 4'b1011; req_outport = '0; req_vc = '0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!outport_busy[0] && n < 10) begin
        tick();
        n++;
      end
      check("t2_granted", 32'(outport_busy[0]), 32'd1);
      check("t2_order", 32'(outport_sel[1:0]), 32'(order[k]));
      packet_sent[0] = 1'b1;
      tick();
      packet_sent[0] = 1'b0;
      check("t2_bubble", 32'(outport_busy[0]), 32'd0);
    end
    clear_inputs();
    tick();

    // Port 1 VC 1 credit exhaustion and return.
    req_valid = 4'b0100; req_outport[5:4] = 2'd1; req_vc[2] = 1'b1;
    tick();
    clear_inputs();
    check("t3_lock", 32'(outport_busy[1]), 32'd1);
    flit_sent[1] = 1'b1;
    repeat (8) tick();
    flit_sent[1] = 1'b0;
    check("t3_empty", 32'(credit_avail[1]), 32'd0);
    credit_granted[3] = 1'b1;
    tick();
    credit_granted = '0;
    check("t3_return", 32'(credit_avail[1]), 32'd1);
    flit_sent[1] = 1'b1; credit_granted[3] = 1'b1;
    tick();
    clear_inputs();
    check("t3_cancel", 32'(credit_avail[1]), 32'd1);
    check("t3_no_err", 32'(credit_err), 32'd0);
    credit_granted[3] = 1'b1;
    repeat (7) tick();
    check("t3_full_no_err", 32'(credit_err), 32'd0);
    tick();
    credit_granted = '0;
    check("t3_overflow_err", 32'(credit_err), 32'd1);
    flit_sent[1] = 1'b1;
    repeat (7) tick();
    flit_sent[1] = 1'b0;
    check("t3_stayed8", 32'(credit_avail[1]), 32'd1);
    packet_sent[1] = 1'b1;
    tick();
    clear_inputs();

    // Port 3 VC 0 exhausted blocks VC 0 requesters only.
    req_valid = 4'b0001; req_outport[1:0] = 2'd3; req_vc[0] = 1'b0;
    tick();
    clear_inputs();
    flit_sent[3] = 1'b1;
    repeat (7) tick();
    flit_sent[3] = 1'b0; packet_sent[3] = 1'b1;
    tick();
    clear_inputs();
    req_valid = 4'b0100; req_outport[5:4] = 2'd3; req_vc[2] = 1'b0;
    tick();
    tick();
    check("t4_blocked", 32'(outport_busy[3]), 32'd0);
    req_valid = 4'b1100; req_outport[7:6] = 2'd3; req_vc[3] = 1'b1;
    tick();
    check("t4_vc1_lock", 32'(outport_busy[3]), 32'd1);
    check("t4_vc1_sel", 32'(outport_sel[7:6]), 32'd3);

    // Reset mid-packet.
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_busy", 32'(outport_busy), 32'd0);
    check("t5_grant", 32'(buffer_grant), 32'd0);
    check("t5_sel", 32'(outport_sel), 32'd0);
    check("t5_err", 32'(credit_err), 32'd0);
    req_valid = 4'b0100; req_outport[5:4] = 2'd3; req_vc[2] = 1'b0;
    tick();
    clear_inputs();
    check("t5_cred_back", 32'(credit_avail[3]), 32'd1);
    packet_sent[3] = 1'b1;
    tick();
    clear_inputs();

`ifdef SWITCH_ALLOC_STATS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_valid = 4'b0001; req_outport = '0; req_vc = '0;
      tick();
      clear_inputs();
      packet_sent[0] = 1'b1;
      tick();
      clear_inputs();
    end
    check("stats_pkt0", 32'(pkt_count[15:0]), 32'd3);
`endif

    // Random traffic.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (500) begin
      req_valid   = 4'($urandom);
      req_outport = 8'($urandom);
      req_vc      = 4'($urandom);
      for (int p = 0; p < NO; p++) begin
        flit_sent[p]   = ($urandom_range(0, 1) == 0);
        packet_sent[p] = ($urandom_range(0, 4) == 0);
      end
      for (int i = 0; i < NO*NV; i++)
        credit_granted[i] = ($urandom_range(0, 3) == 0);
      tick();
    end
    clear_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
